// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button levels in, conditioned levels and
// one-cycle press/release pulses out.
interface button_conditioner_if #(
  parameter int N = 12
);
  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic         any_held;

  // Board side: drives the raw pins and consumes the conditioned outputs.
  modport master (
    output raw_in,
    input  level, press_pulse, release_pulse, any_held
  );

  // Conditioner side.
  modport slave (
    input  raw_in,
    output level, press_pulse, release_pulse, any_held
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: per-channel two-flop sync, press detect,
// debounced release filter and optional auto-repeat. Every output is a flop.

// One button channel. Presses are accepted on the first high synchronised
// sample; bounce after a press is absorbed because a release needs
// DEBOUNCE_CYCLES consecutive low samples while HELD.
module button_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3,
  parameter int CNT_W           = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic level_next,
  output logic press_pulse,
  output logic release_pulse
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEL_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state;
  logic [1:0]       sync_pipe;
  logic             sync;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             phase;     // 0: waiting for first repeat, 1: periodic
  logic [CNT_W-1:0] rep_last;

  assign sync     = sync_pipe[1];
  assign rep_last = phase ? PER_LAST : DEL_LAST;

  // Two-flop synchroniser on the asynchronous button pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_pipe <= 2'b00;
    else        sync_pipe <= {sync_pipe[0], raw};
  end

  // Level the FSM below will register on the next edge; lets the top build a
  // registered any_held with the same latency as level.
  always_comb begin
    level_next = 1'b0;
    case (state)
      IDLE:    level_next = sync;
      PRESSED: level_next = 1'b1;
      HELD:    level_next = !(!sync && (deb_cnt == DEB_LAST));
      default: level_next = 1'b0;
    endcase
  end

  // Channel FSM with registered level and pulse outputs. Counters stop at
  // their thresholds, so they never reach their wrap point.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      rep_cnt       <= '0;
      phase         <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            level       <= 1'b1;
          end
        end
        PRESSED: begin
          state   <= HELD;
          deb_cnt <= '0;
          rep_cnt <= '0;
          phase   <= 1'b0;
        end
        HELD: begin
          if (!sync) begin
            rep_cnt <= '0;
            if (deb_cnt == DEB_LAST) begin
              state         <= IDLE;
              deb_cnt       <= '0;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end else begin
            deb_cnt <= '0;
            if (REPEAT_EN) begin
              // The cycle carrying a repeat pulse is not counted, mirroring
              // the uncounted PRESSED cycle before the first repeat.
              if (press_pulse) begin
                rep_cnt <= '0;
              end else if (rep_cnt == rep_last) begin
                rep_cnt     <= '0;
                phase       <= 1'b1;
                press_pulse <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
              end
            end else begin
              rep_cnt <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end
endmodule

module button_conditioner #(
  parameter int           N               = 12,
  parameter int           DEBOUNCE_CYCLES = 6_250_000,
  parameter logic [N-1:0] REPEAT_MASK     = '0,
  parameter int           REPEAT_DELAY    = 25_000_000,
  parameter int           REPEAT_PERIOD   = 6_250_000
) (
  input logic                 clock,
  input logic                 reset,
  button_conditioner_if.slave bus
);
  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] level_next;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic         any_held;

  assign raw_in = bus.raw_in;

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .raw           (raw_in[i]),
      .level         (level[i]),
      .level_next    (level_next[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

  // any_held registered from the channels' next levels so it tracks level exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) any_held <= 1'b0;
    else        any_held <= |level_next;
  end

  assign bus.level         = level;
  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.any_held      = any_held;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timing scenarios plus randomized
// button traces compared against an event-level reference model.
module tb_button_conditioner;
  localparam int           N    = 3;
  localparam int           DEB  = 4;
  localparam int           RDEL = 8;
  localparam int           RPER = 3;
  localparam logic [N-1:0] RMASK = 3'b100;
  localparam int           MAXL = 600;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   chk   = 0;
  int   pass  = 0;

  logic [N-1:0] stim  [MAXL];
  logic [N-1:0] e_lvl [MAXL];
  logic [N-1:0] e_prs [MAXL];
  logic [N-1:0] e_rel [MAXL];

  button_conditioner_if #(.N(N)) bus ();
  button_conditioner_if #(.N(1)) bus1 ();

  button_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_MASK(RMASK),
    .REPEAT_DELAY(RDEL), .REPEAT_PERIOD(RPER)
  ) dut (.clock(clock), .reset(reset), .bus(bus));

  button_conditioner #(
    .N(1), .DEBOUNCE_CYCLES(1), .REPEAT_MASK(1'b1),
    .REPEAT_DELAY(1), .REPEAT_PERIOD(1)
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  always #5 clock = ~clock;

  // Synchronised sample the FSM sees at edge u for trace index u.
  function automatic logic syn(input int ch, input int u);
    return (u >= 2) ? stim[u-2][ch] : 1'b0;
  endfunction

  // Reference: walk press/release events. A press happens at the first high
  // sample while idle; the release is the end of the first run of d lows
  // starting two edges after the press; repeats need del (then per) consecutive
  // highs, and the edge right after any pulse is not counted.
  task automatic model_ch(input int ch, input int L, input int d, input bit rep,
                          input int del, input int per);
    int p, r, run, highs, thr, end_t;
    bit skip;
    for (int t = 0; t < L; t++) begin
      e_lvl[t][ch] = 1'b0; e_prs[t][ch] = 1'b0; e_rel[t][ch] = 1'b0;
    end
    p = 0;
    while (p < L) begin
      if (!syn(ch, p)) begin
        p++;
      end else begin
        e_prs[p][ch] = 1'b1;
        r = -1; run = 0;
        for (int u = p + 2; u < L && r < 0; u++) begin
          run = syn(ch, u) ? 0 : run + 1;
          if (run == d) r = u;
        end
        end_t = (r < 0) ? L : r;
        for (int u = p; u < end_t; u++) e_lvl[u][ch] = 1'b1;
        if (r >= 0) e_rel[r][ch] = 1'b1;
        if (rep) begin
          highs = 0; thr = del; skip = 1'b0;
          for (int u = p + 2; u < end_t; u++) begin
            if (skip) begin
              skip = 1'b0; highs = 0;
            end else if (!syn(ch, u)) begin
              highs = 0;
            end else begin
              highs++;
              if (highs == thr) begin
                e_prs[u][ch] = 1'b1; thr = per; skip = 1'b1; highs = 0;
              end
            end
          end
        end
        p = (r < 0) ? L : r + 1;
      end
    end
  endtask

  // Random alternating low/high runs per channel.
  task automatic gen_stim(input int L, input int nch, input int max_hi, input int max_lo);
    for (int ch = 0; ch < nch; ch++) begin
      int t = 0;
      bit v = 1'b0;
      while (t < L) begin
        int len = v ? $urandom_range(max_hi, 1) : $urandom_range(max_lo, 1);
        for (int k = 0; k < len && t < L; k++) begin
          stim[t][ch] = v; t++;
        end
        v = !v;
      end
    end
  endtask

  task automatic settle(input int n);
    bus.raw_in  = '0;
    bus1.raw_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    chk++;
    if ({bus.level, bus.press_pulse, bus.release_pulse, bus.any_held} !== '0)
      $display("FAIL reset_initial got %b want 0", {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held});
    else pass++;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    settle(4);
    bus.raw_in = 3'b001;
    repeat (6) @(negedge clock);
    chk++;
    if (bus.level !== 3'b001) $display("FAIL reset_held_before got %b want 001", bus.level);
    else pass++;
    #2 reset = 1'b0;
    #1;
    chk++;
    if ({bus.level, bus.press_pulse, bus.release_pulse, bus.any_held} !== '0)
      $display("FAIL reset_async got %b want 0", {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held});
    else pass++;
    bus.raw_in = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      chk++;
      if ({bus.level, bus.press_pulse, bus.release_pulse, bus.any_held} !== '0)
        $display("FAIL reset_quiet t=%0d got %b want 0", t, {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held});
      else pass++;
    end
  endtask

  task automatic test_clean();
    logic [9:0] exp, act;
    settle(12);
    for (int t = 0; t < 20; t++) begin
      bus.raw_in = (t < 10) ? 3'b001 : 3'b000;
      @(posedge clock); @(negedge clock);
      exp = {((t >= 2 && t < 15) ? 3'b001 : 3'b000), ((t == 2) ? 3'b001 : 3'b000),
             ((t == 15) ? 3'b001 : 3'b000), (t >= 2 && t < 15)};
      act = {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held};
      chk++;
      if (act !== exp) $display("FAIL clean t=%0d got %b want %b", t, act, exp);
      else pass++;
    end
  endtask

  task automatic test_bounce();
    logic [9:0] exp, act;
    logic       r;
    settle(12);
    for (int t = 0; t < 46; t++) begin
      r = (t < 6) ? 1'b1 : (t < 36) ? (((t - 6) % 6) >= 3) : 1'b0;
      bus.raw_in = {1'b0, r, 1'b0};
      @(posedge clock); @(negedge clock);
      exp = {((t >= 2 && t < 41) ? 3'b010 : 3'b000), ((t == 2) ? 3'b010 : 3'b000),
             ((t == 41) ? 3'b010 : 3'b000), (t >= 2 && t < 41)};
      act = {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held};
      chk++;
      if (act !== exp) $display("FAIL bounce t=%0d got %b want %b", t, act, exp);
      else pass++;
    end
  endtask

  task automatic test_repeat();
    logic [9:0] exp, act;
    logic       rp;
    settle(12);
    for (int t = 0; t < 30; t++) begin
      bus.raw_in = (t < 20) ? 3'b101 : 3'b000;
      @(posedge clock); @(negedge clock);
      rp = (t == 2) || (t == 11) || (t == 15) || (t == 19);
      exp = {((t >= 2 && t < 25) ? 3'b101 : 3'b000), {rp, 1'b0, (t == 2)},
             ((t == 25) ? 3'b101 : 3'b000), (t >= 2 && t < 25)};
      act = {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held};
      chk++;
      if (act !== exp) $display("FAIL repeat t=%0d got %b want %b", t, act, exp);
      else pass++;
    end
  endtask

  task automatic test_simultaneous();
    settle(12);
    for (int t = 0; t < 20; t++) begin
      bus.raw_in = (t < 10) ? 3'b111 : 3'b101;
      @(posedge clock); @(negedge clock);
      if (t == 2) begin
        chk++;
        if ({bus.press_pulse, bus.release_pulse, bus.any_held} !== 7'b111_000_1)
          $display("FAIL simul_press got %b want 1110001", {bus.press_pulse, bus.release_pulse, bus.any_held});
        else pass++;
      end
      if (t == 15) begin
        chk++;
        if ({bus.level, bus.release_pulse, bus.any_held} !== 7'b101_010_1)
          $display("FAIL simul_release got %b want 1010101", {bus.level, bus.release_pulse, bus.any_held});
        else pass++;
      end
    end
  endtask

  task automatic test_held_reset();
    settle(12);
    reset = 1'b0;
    bus.raw_in = 3'b001;
    repeat (3) @(negedge clock);
    chk++;
    if ({bus.level, bus.press_pulse} !== 6'b0)
      $display("FAIL held_reset_in got %b want 0", {bus.level, bus.press_pulse});
    else pass++;
    reset = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clock); @(negedge clock);
      chk++;
      if ({bus.press_pulse[0], bus.level[0]} !== {(t == 2), (t >= 2)})
        $display("FAIL held_reset t=%0d got %b want %b", t, {bus.press_pulse[0], bus.level[0]}, {(t == 2), (t >= 2)});
      else pass++;
    end
  endtask

  task automatic test_random();
    logic [9:0]   exp, act;
    logic [N-1:0] rm;
    rm = RMASK;
    gen_stim(MAXL, N, 24, 6);
    for (int ch = 0; ch < N; ch++) model_ch(ch, MAXL, DEB, rm[ch], RDEL, RPER);
    settle(12);
    for (int t = 0; t < MAXL; t++) begin
      bus.raw_in = stim[t];
      @(posedge clock); @(negedge clock);
      exp = {e_lvl[t], e_prs[t], e_rel[t], |e_lvl[t]};
      act = {bus.level, bus.press_pulse, bus.release_pulse, bus.any_held};
      chk++;
      if (act !== exp) $display("FAIL random t=%0d got %b want %b", t, act, exp);
      else pass++;
    end
  endtask

  task automatic test_d1_random();
    logic [3:0] exp, act;
    gen_stim(200, 1, 6, 3);
    model_ch(0, 200, 1, 1'b1, 1, 1);
    settle(12);
    for (int t = 0; t < 200; t++) begin
      bus1.raw_in = stim[t][0];
      @(posedge clock); @(negedge clock);
      exp = {e_lvl[t][0], e_prs[t][0], e_rel[t][0], e_lvl[t][0]};
      act = {bus1.level, bus1.press_pulse, bus1.release_pulse, bus1.any_held};
      chk++;
      if (act !== exp) $display("FAIL d1_random t=%0d got %b want %b", t, act, exp);
      else pass++;
    end
  endtask

  initial begin
    bus.raw_in  = '0;
    bus1.raw_in = 1'b0;
    test_reset();
    test_clean();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_held_reset();
    test_random();
    test_d1_random();
    settle(2);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel input conditioner for the Connect4 board inputs: the column buttons, confirm, player switch, PvP switch, new game and debug select. It generalises the single-channel confirm limiter to N channels. Each channel gets:
- two-flop synchronisation,
- press detection without bounce, with a one-cycle press pulse,
- a release filter that needs a debounced release,
- a one-cycle release pulse,
- optional auto-repeat while the button is held.

It sits between the top-level input pins and the Ownership/PvE logic.

## Interface
Parameters:
- N, 12, number of independent channels (≥1)
- DEBOUNCE_CYCLES, 6_250_000, consecutive low synchronised samples required to accept a release (≥1)
- REPEAT_MASK, '0 (N bits), channel i auto-repeats when bit i = 1
- REPEAT_DELAY, 25_000_000, high samples in HELD before the first repeat pulse (≥1)
- REPEAT_PERIOD, 6_250_000, high samples between later repeat pulses (≥1)
- CNT_W, $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1), counter width (derived, not overridden)

Ports:
- clock  in  1  single design clock; all state on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- raw_in  in  N  unsynchronised button levels, 1 = pressed
- level  out  N  debounced level, 1 while channel in PRESSED or HELD
- press_pulse  out  N  one-cycle pulse on accepted press or repeat
- release_pulse  out  N  one-cycle pulse on accepted release
- any_held  out  1  OR-reduction of level

## Operation
- Reset (reset=0): sync flops, states, counters and outputs go to 0; states go to IDLE.
- Per channel, sync_i is the second flop of a two-flop chain on raw_in[i].
- FSM states: IDLE, PRESSED, HELD.
  - IDLE: if sync_i=1, go to PRESSED; otherwise stay.
  - PRESSED: lasts exactly one cycle; press_pulse=1, level=1; always go to HELD; clear deb_cnt and rep_cnt.
  - HELD, sync_i=0: deb_cnt+1 and rep_cnt cleared. When deb_cnt == DEBOUNCE_CYCLES-1, go to IDLE, assert release_pulse for one cycle and drop level in that same cycle.
  - HELD, sync_i=1: deb_cnt cleared, so any high sample restarts the release filter.
  - HELD, sync_i=1, repeat enabled (REPEAT_MASK[i]=1): rep_cnt+1. The first repeat fires when rep_cnt reaches REPEAT_DELAY-1; later repeats fire every REPEAT_PERIOD-1. Each repeat asserts press_pulse for one cycle and clears rep_cnt. A phase bit selects between the DELAY and PERIOD thresholds.
  - HELD, repeat disabled: rep_cnt is held at 0.
- Low glitches in HELD shorter than DEBOUNCE_CYCLES produce no pulses and leave level at 1.
- No minimum hold time applies; press bounce is absorbed by the release filter.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- Counters saturate and never wrap, because their thresholds end them before overflow.
- DEBOUNCE_CYCLES=1: a release needs only one low sample.

## Timing
- All outputs are registered.
- Press latency:
  - raw_in[i] is sampled high at edge k and sync_i=1 after edge k+1.
  - press_pulse[i]=1 and level[i]=1 in the cycle after edge k+2, i.e. 3 edges.
- Release latency:
  - If sync_i is first low after edge m, release_pulse[i]=1 in the cycle after edge m+DEBOUNCE_CYCLES.
  - level[i]=0 in that same cycle.
- press_pulse and release_pulse are never both 1 on one channel in the same cycle.
- A re-press is detected at the earliest in the cycle after release_pulse: IDLE evaluates sync_i on the next edge.
- Reset asserted mid-operation: all outputs drop asynchronously, and no release_pulse is generated.
- Button held through reset deassertion: press_pulse appears 3 edges after the first edge with reset=1.
- any_held is registered alongside level and so has the same latency.

## Test plan
- Reset values. Use N=3, DEBOUNCE_CYCLES=4. Drive reset=0 mid-run with channel 0 in HELD → all outputs are 0 immediately. After release, raw_in=3'b000 for 10 cycles → no pulses.
- Clean press/release (N=3, DEBOUNCE_CYCLES=4). raw_in[0] goes 0→1 at edge 10 → press_pulse[0] is high for exactly the cycle after edge 12. raw_in[0] goes 1→0 at edge 20 → release_pulse[0] is high for the cycle after edge 25 and level[0] falls then.
- Bounce filter. While held, raw_in[1] gives 3-cycle low glitches ×5 → no extra press or release pulses and level[1] stays 1. A final 4-cycle low gives a single release_pulse[1].
- Auto-repeat (REPEAT_MASK=3'b100, REPEAT_DELAY=8, REPEAT_PERIOD=3, raw_in[2] held for 20 cycles):
  - press_pulse[2] fires at T (the initial press), then at T+9, T+13 and T+17.
  - Channel 0 held equally long gives a single pulse.
- Simultaneous channels. raw_in goes 3'b000→3'b111 at one edge → press_pulse=3'b111 in the same cycle and any_held=1. Release of channel 1 only → release_pulse=3'b010, and any_held stays 1.
- Held through reset. Hold raw_in[0]=1 and deassert reset at edge 0 → press_pulse[0] is high for the cycle after edge 2 and level[0]=1 from then on.
